// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Fetch stage front end. It issues sequential word reads to an instruction
//   memory with a one-cycle read latency. Returned words are buffered in a
//   2-entry FIFO of {pc, word}, and the FIFO head is presented to the control
//   decoder. A redirect flushes everything and reloads the PC.
//
// Parameters:
//   RESET_PC   - first fetch address after reset
//   NOP_WORD   - word presented while no valid instruction is held
//
// Ports:
//   clk                 in   sole clock, rising edge
//   rst_n               in   synchronous active-low reset
//   imem_req            out  instruction memory read strobe
//   imem_addr   [31:0]  out  byte address of the read (word aligned)
//   imem_rdata  [31:0]  in   read data, valid the cycle after imem_req
//   stall               in   decoder not accepting this cycle
//   redirect_en         in   flush pipeline and load redirect_pc
//   redirect_pc [31:0]  in   new fetch address (bits [1:0] ignored)
//   instruction_memory  out  instruction word presented to the decoder
//   instr_valid         out  instruction_memory holds a real fetched word
//   instr_pc    [31:0]  out  address of the presented word (0 when invalid)
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0400_001F
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction_memory,
  output logic        instr_valid,
  output logic [31:0] instr_pc
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

  logic [31:0] pc_reg;
  logic [31:0] inflight_pc_reg;
  logic        inflight_reg;
  logic [1:0]  count_reg;
  logic [1:0]  count_next;

  logic [31:0] fifo_pc_reg   [2];
  logic [31:0] fifo_word_reg [2];
  logic [31:0] fifo_pc_next  [2];
  logic [31:0] fifo_word_next[2];

  logic        pop;
  logic        capture;
  logic [1:0]  occupancy;
  logic [1:0]  wr_slot;

  // Gating with rst_n keeps the outputs quiet during the reset cycle itself,
  // not only after the reset edge has cleared the state.
  assign instr_valid = rst_n & (count_reg != 2'd0);
  assign pop         = instr_valid & ~stall & ~redirect_en;

  // Words owed to the FIFO once this cycle's pop is taken into account.
  // count + inflight never exceeds 2, so two bits cannot overflow.
  assign occupancy = count_reg + {1'b0, inflight_reg} - {1'b0, pop};

  assign imem_req  = rst_n & ~redirect_en & (occupancy <= 2'd1);
  assign imem_addr = pc_reg;

  // A response arriving in a redirect cycle belongs to the old stream.
  assign capture = inflight_reg & ~redirect_en;

  assign wr_slot    = count_reg - {1'b0, pop};
  assign count_next = count_reg + {1'b0, capture} - {1'b0, pop};

  // Per-entry next state: a capture lands in the first free slot after the
  // pop; otherwise a pop shifts entry 1 down to the head.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
      always_comb begin
        fifo_pc_next[gi]   = fifo_pc_reg[gi];
        fifo_word_next[gi] = fifo_word_reg[gi];
        if (capture && (wr_slot == 2'(gi))) begin
          fifo_pc_next[gi]   = inflight_pc_reg;
          fifo_word_next[gi] = imem_rdata;
        end else if (pop && (gi == 0)) begin
          fifo_pc_next[gi]   = fifo_pc_reg[1];
          fifo_word_next[gi] = fifo_word_reg[1];
        end
      end

      // Payload needs no reset: it is only visible while count covers it.
      always_ff @(posedge clk) begin
        fifo_pc_reg[gi]   <= fifo_pc_next[gi];
        fifo_word_reg[gi] <= fifo_word_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC_ALIGNED;
      inflight_pc_reg <= 32'h0;
      inflight_reg    <= 1'b0;
      count_reg       <= 2'd0;
    end else if (redirect_en) begin
      pc_reg       <= redirect_pc & ALIGN_MASK;
      inflight_reg <= 1'b0;
      count_reg    <= 2'd0;
    end else begin
      if (imem_req) begin
        pc_reg          <= pc_reg + 32'd4;   // wraps naturally at 2^32
        inflight_pc_reg <= pc_reg;
      end
      inflight_reg <= imem_req;
      count_reg    <= count_next;
    end
  end

  assign instruction_memory = instr_valid ? fifo_word_reg[0] : NOP_WORD;
  assign instr_pc           = instr_valid ? fifo_pc_reg[0]   : 32'h0;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Self-checking bench for instruction_fetch. Memory word at byte address a is
// 32'h0400_0020 + a/4; cycles without a request return random garbage so any
// wrongly captured response is visible.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0400_001F;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_memory;
  logic        instr_valid;
  logic [31:0] instr_pc;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_word;
  logic        w_valid;
  logic [31:0] w_pc;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .instruction_memory(instruction_memory), .instr_valid(instr_valid),
    .instr_pc(instr_pc)
  );

  instruction_fetch #(.RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .stall(1'b0), .redirect_en(1'b0), .redirect_pc(32'h0),
    .instruction_memory(w_word), .instr_valid(w_valid), .instr_pc(w_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0400_0020 + (a >> 2);
  endfunction

  // One-cycle-latency memories.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom;
    w_rdata    <= w_req ? mem_word(w_addr) : $urandom;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Leaves the bench in the first cycle with rst_n=1 (cycle 0).
  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick(); settle();
      n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      n_cmp++; if (instruction_memory !== NOP) begin n_fail++; $display("FAIL reset_word: got %h want %h", instruction_memory, NOP); end
      n_cmp++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
      n_cmp++; if (w_req !== 1'b0 || w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wrap_dut: req %b valid %b want 0 0", w_req, w_valid); end
    end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      logic [31:0] pc_e;
      pc_e = 32'(4 * (c - 2));
      settle();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * c)) begin n_fail++; $display("FAIL stream_req c%0d: req %b addr %h want 1 %h", c, imem_req, imem_addr, 32'(4 * c)); end
      n_cmp++; if (instr_valid !== (c >= 2)) begin n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", c, instr_valid, c >= 2); end
      if (c >= 2) begin
        n_cmp++; if (instr_pc !== pc_e || instruction_memory !== mem_word(pc_e)) begin n_fail++; $display("FAIL stream_head c%0d: pc %h word %h want %h %h", c, instr_pc, instruction_memory, pc_e, mem_word(pc_e)); end
      end else begin
        n_cmp++; if (instr_pc !== 32'h0 || instruction_memory !== NOP) begin n_fail++; $display("FAIL stream_idle c%0d: pc %h word %h want 0 %h", c, instr_pc, instruction_memory, NOP); end
      end
      tick();
    end
    $display("test_stream done");
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      logic [31:0] a_e;
      a_e = WRAP_PC + 32'(4 * c);
      settle();
      n_cmp++; if (w_req !== 1'b1 || w_addr !== a_e) begin n_fail++; $display("FAIL wrap_addr c%0d: req %b addr %h want 1 %h", c, w_req, w_addr, a_e); end
      if (c >= 2) begin
        n_cmp++; if (w_valid !== 1'b1 || w_pc !== WRAP_PC + 32'(4 * (c - 2)) || w_word !== mem_word(w_pc)) begin n_fail++; $display("FAIL wrap_head c%0d: valid %b pc %h word %h", c, w_valid, w_pc, w_word); end
      end
      tick();
    end
    $display("test_wrap done");
  endtask

  task automatic test_stall();
    int reqs;
    do_reset();
    for (int c = 0; c < 4; c++) tick();
    stall = 1'b1;
    reqs = 0;
    for (int k = 0; k < 5; k++) begin
      settle();
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instruction_memory !== mem_word(32'h8)) begin n_fail++; $display("FAIL stall_hold k%0d: valid %b pc %h word %h want 1 8 %h", k, instr_valid, instr_pc, instruction_memory, mem_word(32'h8)); end
      if (imem_req === 1'b1) reqs++;
      tick();
    end
    n_cmp++; if (reqs > 2) begin n_fail++; $display("FAIL stall_reqs: got %0d want <=2", reqs); end
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] pc_e;
      pc_e = 32'(8 + 4 * k);
      settle();
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== pc_e || instruction_memory !== mem_word(pc_e)) begin n_fail++; $display("FAIL stall_release k%0d: valid %b pc %h word %h want 1 %h", k, instr_valid, instr_pc, instruction_memory, pc_e); end
      tick();
    end
    $display("test_stall done");
  endtask

  // s=0: redirect mid-stream with a response arriving; s=1: redirect with a
  // full FIFO while stall is also asserted.
  task automatic test_redirect();
    for (int s = 0; s < 2; s++) begin
      logic [31:0] tgt;
      logic [31:0] base;
      tgt  = (s == 0) ? 32'h0000_0103 : 32'h0000_2002;
      base = tgt & 32'hFFFF_FFFC;
      do_reset();
      for (int c = 0; c < 3; c++) tick();
      if (s == 1) begin
        stall = 1'b1;
        tick(); tick();
      end
      redirect_en = 1'b1; redirect_pc = tgt;
      settle();
      n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req s%0d: got %b want 0", s, imem_req); end
      tick();
      redirect_en = 1'b0; stall = 1'b0; redirect_pc = $urandom;
      for (int k = 0; k < 6; k++) begin
        settle();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== base + 32'(4 * k)) begin n_fail++; $display("FAIL redir_addr s%0d k%0d: req %b addr %h want 1 %h", s, k, imem_req, imem_addr, base + 32'(4 * k)); end
        n_cmp++; if (instr_valid !== (k >= 2)) begin n_fail++; $display("FAIL redir_valid s%0d k%0d: got %b want %b", s, k, instr_valid, k >= 2); end
        if (k >= 2) begin
          n_cmp++; if (instr_pc !== base + 32'(4 * (k - 2)) || instruction_memory !== mem_word(instr_pc)) begin n_fail++; $display("FAIL redir_head s%0d k%0d: pc %h word %h want %h", s, k, instr_pc, instruction_memory, base + 32'(4 * (k - 2))); end
        end
        tick();
      end
    end
    $display("test_redirect done");
  endtask

  task automatic test_back_to_back_redirect();
    do_reset();
    for (int c = 0; c < 3; c++) tick();
    redirect_en = 1'b1; redirect_pc = 32'h0000_0500;
    tick();
    redirect_pc = 32'h0000_0A0D;
    settle();
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_mid: req %b valid %b want 0 0", imem_req, instr_valid); end
    tick();
    redirect_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_cmp++; if (imem_addr !== 32'h0A0C + 32'(4 * k) || imem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_addr k%0d: req %b addr %h want 1 %h", k, imem_req, imem_addr, 32'h0A0C + 32'(4 * k)); end
      n_cmp++; if (instr_valid !== (k >= 2) || (k >= 2 && instr_pc !== 32'h0A0C + 32'(4 * (k - 2)))) begin n_fail++; $display("FAIL b2b_head k%0d: valid %b pc %h", k, instr_valid, instr_pc); end
      tick();
    end
    $display("test_back_to_back_redirect done");
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int c = 0; c < 3; c++) tick();
    rst_n = 1'b0;
    settle();
    n_cmp++; if (instr_valid !== 1'b0 || instruction_memory !== NOP || imem_req !== 1'b0 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_hold: valid %b word %h req %b pc %h", instr_valid, instruction_memory, imem_req, instr_pc); end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL midrst_addr k%0d: req %b addr %h want 1 %h", k, imem_req, imem_addr, 32'(4 * k)); end
      n_cmp++; if (instr_valid !== (k >= 2)) begin n_fail++; $display("FAIL midrst_valid k%0d: got %b want %b", k, instr_valid, k >= 2); end
      if (k >= 2) begin
        n_cmp++; if (instr_pc !== 32'(4 * (k - 2)) || instruction_memory !== mem_word(32'(4 * (k - 2)))) begin n_fail++; $display("FAIL midrst_head k%0d: pc %h word %h", k, instr_pc, instruction_memory); end
      end else begin
        n_cmp++; if (instruction_memory !== NOP) begin n_fail++; $display("FAIL midrst_nop k%0d: got %h want %h", k, instruction_memory, NOP); end
      end
      tick();
    end
    $display("test_mid_reset done");
  endtask

  // Reference model: a queue of issue cycles for words requested but not yet
  // consumed. A word is presentable two cycles after its request; requests
  // are allowed while the outstanding total after this cycle's pop is <= 1.
  task automatic test_random();
    int q[$];
    logic [31:0] fetch_exp;
    logic [31:0] present_exp;
    do_reset();
    fetch_exp = 32'h0; present_exp = 32'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit valid_e, pop_e, req_e;
      stall       = ($urandom_range(0, 9) < 3);
      redirect_en = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      settle();
      valid_e = (q.size() > 0) && (q[0] + 2 <= cyc);
      pop_e   = valid_e && !stall && !redirect_en;
      req_e   = !redirect_en && ((q.size() - int'(pop_e)) <= 1);
      n_cmp++; if (instr_valid !== valid_e) begin n_fail++; $display("FAIL rand_valid cyc%0d: got %b want %b", cyc, instr_valid, valid_e); end
      if (valid_e) begin
        n_cmp++; if (instr_pc !== present_exp || instruction_memory !== mem_word(present_exp)) begin n_fail++; $display("FAIL rand_head cyc%0d: pc %h word %h want %h %h", cyc, instr_pc, instruction_memory, present_exp, mem_word(present_exp)); end
      end else begin
        n_cmp++; if (instr_pc !== 32'h0 || instruction_memory !== NOP) begin n_fail++; $display("FAIL rand_idle cyc%0d: pc %h word %h want 0 %h", cyc, instr_pc, instruction_memory, NOP); end
      end
      n_cmp++; if (imem_req !== req_e) begin n_fail++; $display("FAIL rand_req cyc%0d: got %b want %b", cyc, imem_req, req_e); end
      if (req_e) begin
        n_cmp++; if (imem_addr !== fetch_exp) begin n_fail++; $display("FAIL rand_addr cyc%0d: got %h want %h", cyc, imem_addr, fetch_exp); end
      end
      if (redirect_en) begin
        q.delete();
        fetch_exp   = redirect_pc & 32'hFFFF_FFFC;
        present_exp = fetch_exp;
      end else begin
        if (pop_e) begin
          void'(q.pop_front());
          present_exp = present_exp + 32'd4;
        end
        if (req_e) begin
          q.push_back(cyc);
          fetch_exp = fetch_exp + 32'd4;
        end
      end
      tick();
    end
    stall = 1'b0; redirect_en = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_stall();
    test_redirect();
    test_back_to_back_redirect();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
